// File: rtl/serial_receiver_if.sv
// Output side of the serial receiver: valid/ready holding register plus status flags.
//   master: driven by serial_receiver (data_out, parity_err, out_valid, overrun out; out_ready in)
//   slave : the consumer (out_ready out; everything else in)
interface serial_receiver_if #(
  parameter int unsigned DATA_BITS = 7
);
  logic                 out_ready;
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_err;
  logic                 out_valid;
  logic                 overrun;

  modport master (
    input  out_ready,
    output data_out,
    output parity_err,
    output out_valid,
    output overrun
  );

  modport slave (
    output out_ready,
    input  data_out,
    input  parity_err,
    input  out_valid,
    input  overrun
  );
endinterface

// File: rtl/serial_receiver.sv
// Serial frame receiver.
// Deserialises frames of: start bit 0, DATA_BITS data bits LSB first, one even-parity bit.
// Each received word is presented through a single-entry valid/ready holding register.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   serial_in  serial line, idle high, already synchronous to clk
//   rx         output interface (master): data_out, parity_err, out_valid, overrun, out_ready
module serial_receiver #(
  parameter int unsigned DATA_BITS    = 7,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  serial_receiver_if.master rx
);

  localparam int unsigned TickW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);

  // Tick counter holds "edges remaining before the next sample"; sampling happens at zero.
  localparam logic [TickW-1:0]   TickHalf = TickW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TickW-1:0]   TickFull = TickW'(CLKS_PER_BIT - 1);
  localparam logic [BitCntW-1:0] LastBit  = BitCntW'(DATA_BITS);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StStart    = 2'd1;
  localparam logic [1:0] StData     = 2'd2;
  localparam logic [1:0] StWaitIdle = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic frame_done;
  logic frame_perr;
  logic tick_done;

  assign tick_done = (tick_q == '0);

  // Frame reception FSM
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    frame_perr = 1'b0;

    case (state_q)
      StIdle: begin
        if (!serial_in) begin
          bit_cnt_d = '0;
          if (CLKS_PER_BIT == 1) begin
            state_d = StData;
            tick_d  = '0;
          end else begin
            state_d = StStart;
            tick_d  = TickHalf;
          end
        end
      end

      StStart: begin
        if (tick_done) begin
          // Re-check mid start bit; a line back high was a glitch.
          if (!serial_in) begin
            state_d = StData;
            tick_d  = TickFull;
          end else begin
            state_d = StIdle;
          end
        end else begin
          tick_d = tick_q - TickW'(1);
        end
      end

      StData: begin
        if (tick_done) begin
          tick_d = TickFull;
          if (bit_cnt_q == LastBit) begin
            // This sample is the parity bit; shift_q holds the complete word.
            frame_done = 1'b1;
            frame_perr = serial_in ^ (^shift_q);
            state_d    = StWaitIdle;
          end else begin
            shift_d   = {serial_in, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end else begin
          tick_d = tick_q - TickW'(1);
        end
      end

      StWaitIdle: begin
        // A low line after the frame must not be mistaken for a new start bit.
        if (serial_in) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Holding register and handshake
  always_comb begin
    data_d    = data_q;
    perr_d    = perr_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (valid_q && rx.out_ready) begin
      valid_d = 1'b0;
    end

    if (frame_done) begin
      // Space exists if the register is empty or is being drained this cycle.
      if (!valid_q || rx.out_ready) begin
        data_d  = shift_q;
        perr_d  = frame_perr;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx.data_out   = data_q;
  assign rx.parity_err = perr_q;
  assign rx.out_valid  = valid_q;
  assign rx.overrun    = overrun_q;

endmodule

// File: tb/tb_serial_receiver.sv
module tb_serial_receiver;

  logic clk;
  logic rst;
  logic line1;
  logic line4;

  int n_chk;
  int n_fail;

  serial_receiver_if #(.DATA_BITS(7)) if1 ();
  serial_receiver_if #(.DATA_BITS(7)) if4 ();

  serial_receiver #(.DATA_BITS(7), .CLKS_PER_BIT(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .serial_in (line1),
    .rx        (if1)
  );

  serial_receiver #(.DATA_BITS(7), .CLKS_PER_BIT(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .serial_in (line4),
    .rx        (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic par(input logic [6:0] w);
    return ^w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit per clk. Returns just after the edge that samples the parity bit,
  // with the line set to end_level.
  task automatic send1(input logic [6:0] w, input logic p, input logic end_level,
                       input bit chk_pre, input bit rdy_last);
    logic [8:0] bits;
    bits = {p, w, 1'b0};
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      line1 = bits[k];
    end
    if (chk_pre || rdy_last) begin
      @(negedge clk);
      if (chk_pre) chk("latency_pre_valid", 32'(if1.out_valid), 32'd0);
      if (rdy_last) if1.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    line1 = end_level;
  endtask

  // Four clks per bit, line returns high afterwards.
  task automatic send4(input logic [6:0] w, input logic p);
    logic [8:0] bits;
    bits = {p, w, 1'b0};
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      line4 = bits[k];
      repeat (3) @(posedge clk);
    end
    @(posedge clk); #1;
    line4 = 1'b1;
  endtask

  task automatic expect_word1(input string tag, input logic [6:0] w, input logic perr);
    chk({tag, "_valid"}, 32'(if1.out_valid), 32'd1);
    chk({tag, "_data"}, 32'(if1.data_out), 32'(w));
    chk({tag, "_perr"}, 32'(if1.parity_err), 32'(perr));
  endtask

  initial begin
    logic [6:0] w;
    logic       p;
    logic       bad;
    int         hold;
    int         gap;

    n_chk         = 0;
    n_fail        = 0;
    rst           = 1'b1;
    line1         = 1'b1;
    line4         = 1'b1;
    if1.out_ready = 1'b0;
    if4.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid", 32'(if1.out_valid), 32'd0);
    chk("rst_data", 32'(if1.data_out), 32'd0);
    chk("rst_perr", 32'(if1.parity_err), 32'd0);
    chk("rst_overrun", 32'(if1.overrun), 32'd0);
    chk("rst4_valid", 32'(if4.out_valid), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: basic frame, valid exactly one cycle when consumer is ready
    if1.out_ready = 1'b1;
    send1(7'h55, par(7'h55), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    expect_word1("t1", 7'h55, 1'b0);
    @(negedge clk);
    chk("t1_valid_one_cycle", 32'(if1.out_valid), 32'd0);

    // 2: wrong parity still delivered, flagged
    send1(7'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    expect_word1("t2", 7'h01, 1'b1);
    @(negedge clk);

    // 3: overrun while holding register full
    if1.out_ready = 1'b0;
    send1(7'h12, par(7'h12), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_word1("t3a", 7'h12, 1'b0);
    send1(7'h34, par(7'h34), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_overrun_pulse", 32'(if1.overrun), 32'd1);
    expect_word1("t3b", 7'h12, 1'b0);
    @(negedge clk);
    chk("t3_overrun_clear", 32'(if1.overrun), 32'd0);
    chk("t3_still_valid", 32'(if1.out_valid), 32'd1);
    if1.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_drained", 32'(if1.out_valid), 32'd0);

    // Simultaneous accept and new frame: new word replaces old, no overrun
    if1.out_ready = 1'b0;
    send1(7'h66, par(7'h66), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_word1("sim_a", 7'h66, 1'b0);
    send1(7'h19, par(7'h19), 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    expect_word1("sim_b", 7'h19, 1'b0);
    chk("sim_no_overrun", 32'(if1.overrun), 32'd0);
    @(negedge clk);
    chk("sim_drained", 32'(if1.out_valid), 32'd0);

    // 4: low line after a frame is not a start bit
    send1(7'h2A, par(7'h2A), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_word1("t4a", 7'h2A, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("t4_no_spurious", 32'(if1.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    line1 = 1'b1;
    send1(7'h03, par(7'h03), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    expect_word1("t4b", 7'h03, 1'b0);
    @(negedge clk);
    chk("t4_two_words_only", 32'(if1.out_valid), 32'd0);

    // 5: reset mid-frame with a word held
    if1.out_ready = 1'b0;
    send1(7'h6C, par(7'h6C), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_word1("t5_held", 7'h6C, 1'b0);
    begin
      logic [8:0] bits;
      bits = {par(7'h5A), 7'h5A, 1'b0};
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        line1 = bits[k];
      end
    end
    @(posedge clk); #1;
    rst   = 1'b1;
    line1 = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", 32'(if1.out_valid), 32'd0);
    chk("t5_rst_data", 32'(if1.data_out), 32'd0);
    chk("t5_rst_perr", 32'(if1.parity_err), 32'd0);
    chk("t5_rst_overrun", 32'(if1.overrun), 32'd0);
    rst           = 1'b0;
    if1.out_ready = 1'b1;
    @(negedge clk);
    send1(7'h7F, par(7'h7F), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    expect_word1("t5_after", 7'h7F, 1'b0);
    @(negedge clk);

    // Randomised frames against the reference model: word and parity verdict
    for (int i = 0; i < 24; i++) begin
      w    = 7'($urandom);
      bad  = ($urandom_range(0, 3) == 0);
      p    = par(w) ^ bad;
      hold = $urandom_range(0, 3);
      gap  = $urandom_range(0, 3);
      if1.out_ready = (hold == 0);
      repeat (gap) @(posedge clk);
      send1(w, p, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      expect_word1("rand", w, (p != par(w)));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("rand_hold_valid", 32'(if1.out_valid), 32'd1);
        chk("rand_hold_data", 32'(if1.data_out), 32'(w));
      end
      if1.out_ready = 1'b1;
      @(negedge clk);
      chk("rand_drained", 32'(if1.out_valid), 32'd0);
    end

    // 6: four clocks per bit, glitch rejection then a real frame
    @(posedge clk); #1;
    line4 = 1'b0;
    @(posedge clk); #1;
    line4 = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t6_glitch_rejected", 32'(if4.out_valid), 32'd0);
    send4(7'h41, par(7'h41));
    @(negedge clk);
    chk("t6_valid", 32'(if4.out_valid), 32'd1);
    chk("t6_data", 32'(if4.data_out), 32'h41);
    chk("t6_perr", 32'(if4.parity_err), 32'd0);
    if4.out_ready = 1'b1;
    @(negedge clk);
    chk("t6_drained", 32'(if4.out_valid), 32'd0);
    send4(7'h2D, ~par(7'h2D));
    @(negedge clk);
    chk("t6b_data", 32'(if4.data_out), 32'h2D);
    chk("t6b_perr", 32'(if4.parity_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
